// File: rtl/cmd_issue_arbiter_if.sv
// Command-path types and the arbiter's buffer/tag/credit bundle toward the
// command buffers, tag buffer and PSL credit logic.
package cmd_issue_arbiter_pkg;
  typedef logic [3:0] arb_request_t;

  typedef struct packed {
    logic [7:0] tag;
    logic [3:0] cu_id;
    logic [1:0] cmd_type;
  } cu_cmd_t;

  typedef struct packed {
    cu_cmd_t     cmd;
    logic [31:0] address;
    logic [15:0] data;
  } cmd_payload_t;

  typedef struct packed {
    logic [12:0] command;
    logic [7:0]  tag;
    logic [11:0] size;
  } psl_cmd_t;

  typedef struct packed {
    logic         valid;
    psl_cmd_t     cmd;
    cmd_payload_t payload;
  } cmd_buffer_line_t;
endpackage

interface cmd_issue_arbiter_if #(
  parameter int CREDIT_W = 9,
  parameter int NUM_REQ  = 4
);
  import cmd_issue_arbiter_pkg::*;

  logic                enabled_in;
  logic [7:0]          init_credits_in;
  logic                credit_return_in;
  arb_request_t        request_in;
  cmd_buffer_line_t    cmd_buffer_in [NUM_REQ];
  logic                tag_valid_in;
  logic [7:0]          tag_in;
  logic                tag_pop_out;
  logic [NUM_REQ-1:0]  grant_out;
  cmd_buffer_line_t    command_out;
  logic [CREDIT_W-1:0] credits_out;
  logic                credit_error_out;

  modport master (
    input  enabled_in, init_credits_in, credit_return_in, request_in,
           cmd_buffer_in, tag_valid_in, tag_in,
    output tag_pop_out, grant_out, command_out, credits_out, credit_error_out
  );

  modport slave (
    output enabled_in, init_credits_in, credit_return_in, request_in,
           cmd_buffer_in, tag_valid_in, tag_in,
    input  tag_pop_out, grant_out, command_out, credits_out, credit_error_out
  );
endinterface

// File: rtl/cmd_issue_arbiter.sv
// PSL command issue arbiter: restart strict priority, wed/write/read fixed
// priority, or round-robin when CMD_ARB_ROUND_ROBIN_EN is defined; credit tracking.
module cmd_issue_arbiter #(
  parameter int CREDIT_W = 9,
  parameter int NUM_REQ  = 4
) (
  input logic              clock,
  input logic              reset,
  cmd_issue_arbiter_if.master bus
);
  import cmd_issue_arbiter_pkg::*;

  typedef enum logic [1:0] {ST_RESET, ST_INIT, ST_ARBITRATE, ST_IDLE} state_t;

  state_t              state;
  logic [CREDIT_W-1:0] credits;
  logic [CREDIT_W-1:0] ceiling;
  logic                credit_error;
  cmd_buffer_line_t    command_p1;
  logic [NUM_REQ-1:0]  eligible;
  logic [1:0]          sel;
  logic [1:0]          slot;
  logic [1:0]          rr_ptr;
  logic                found;
  logic                can_issue;
  logic                issue;

  function automatic logic [CREDIT_W-1:0] next_credits(
    input logic [CREDIT_W-1:0] cur,
    input logic [CREDIT_W-1:0] ceil,
    input logic                take,
    input logic                give
  );
    if (take && !give) return cur - CREDIT_W'(1);
    if (give && !take && cur != ceil) return cur + CREDIT_W'(1);
    return cur;
  endfunction

  // Non-restart positions are 1..3; slot k counts forward from the pointer.
  function automatic logic [1:0] rr_slot(input logic [1:0] ptr, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, ptr} + {1'b0, k};
    return (s > 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      eligible[i] = bus.request_in[i] & bus.cmd_buffer_in[i].valid;
  end

  always_comb begin
    sel   = 2'd0;
    slot  = 2'd0;
    found = 1'b0;
    if (eligible[0]) begin
      found = 1'b1;
    end else begin
      for (int k = 0; k < 3; k++) begin
        slot = rr_slot(rr_ptr, 2'(k));
        if (!found && eligible[slot]) begin
          sel   = slot;
          found = 1'b1;
        end
      end
    end
  end

  // enabled_in gates combinationally so a falling enable blocks issue at once.
  assign can_issue = (state == ST_ARBITRATE) && bus.enabled_in &&
                     (credits != '0) && bus.tag_valid_in;
  assign issue     = can_issue && found;

  assign bus.grant_out        = issue ? (NUM_REQ'(1) << sel) : '0;
  assign bus.tag_pop_out      = issue;
  assign bus.command_out      = command_p1;
  assign bus.credits_out      = credits;
  assign bus.credit_error_out = credit_error;

`ifdef CMD_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr <= 2'd1;
    end else if (issue && sel != 2'd0) begin
      rr_ptr <= (sel == 2'd3) ? 2'd1 : sel + 2'd1;
    end
  end
`else
  assign rr_ptr = 2'd1;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_RESET;
      credits      <= '0;
      ceiling      <= '0;
      credit_error <= 1'b0;
      command_p1   <= '0;
    end else begin
      // p1: granted head with the fresh tag stamped into both tag fields
      command_p1 <= '0;
      if (issue) begin
        command_p1                 <= bus.cmd_buffer_in[sel];
        command_p1.cmd.tag         <= bus.tag_in;
        command_p1.payload.cmd.tag <= bus.tag_in;
        command_p1.valid           <= 1'b1;
      end
      case (state)
        ST_RESET: begin
          if (bus.enabled_in) state <= ST_INIT;
        end
        ST_INIT: begin
          credits <= {{(CREDIT_W-8){1'b0}}, bus.init_credits_in};
          ceiling <= {{(CREDIT_W-8){1'b0}}, bus.init_credits_in};
          state   <= ST_ARBITRATE;
        end
        ST_ARBITRATE: begin
          credits <= next_credits(credits, ceiling, issue, bus.credit_return_in);
          if (bus.credit_return_in && !issue && credits == ceiling)
            credit_error <= 1'b1;
          if (!bus.enabled_in) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (bus.enabled_in) state <= ST_ARBITRATE;
        end
        default: state <= ST_RESET;
      endcase
    end
  end
endmodule

// File: tb/tb_cmd_issue_arbiter.sv
// Directed plus randomized bench for cmd_issue_arbiter against a queue-based reference model.
module tb_cmd_issue_arbiter;
  import cmd_issue_arbiter_pkg::*;

  localparam int CREDIT_W = 9;
  localparam int NUM_REQ  = 4;
  localparam int PH_RESET = 0;
  localparam int PH_INIT  = 1;
  localparam int PH_ARB   = 2;
  localparam int PH_IDLE  = 3;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  cmd_issue_arbiter_if #(.CREDIT_W(CREDIT_W), .NUM_REQ(NUM_REQ)) bus ();

  cmd_issue_arbiter #(.CREDIT_W(CREDIT_W), .NUM_REQ(NUM_REQ)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.master)
  );

  int               n_cmp;
  int               n_fail;
  int               grants_seen;
  int               m_phase;
  int               m_credits;
  int               m_ceil;
  logic             m_err;
  int               m_order[$];
  cmd_buffer_line_t m_cmd;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_buffer_line_t rand_line(input logic v);
    cmd_buffer_line_t l;
    l                  = '0;
    l.valid            = v;
    l.cmd.command      = 13'($urandom);
    l.cmd.tag          = 8'($urandom);
    l.cmd.size         = 12'($urandom);
    l.payload.cmd      = 14'($urandom);
    l.payload.address  = $urandom;
    l.payload.data     = 16'($urandom);
    return l;
  endfunction

  task automatic model_reset();
    m_phase   = PH_RESET;
    m_credits = 0;
    m_ceil    = 0;
    m_err     = 1'b0;
    m_cmd     = '0;
    m_order   = {1, 2, 3};
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 128'(bus.grant_out), 128'(0));
    chk({tag, "_tag_pop"}, 128'(bus.tag_pop_out), 128'(0));
    chk({tag, "_command"}, 128'(bus.command_out), 128'(0));
    chk({tag, "_credits"}, 128'(bus.credits_out), 128'(0));
    chk({tag, "_error"}, 128'(bus.credit_error_out), 128'(0));
  endtask

  // One clock: check combinational grant now, advance the model, check registers after the edge.
  task automatic cycle(input string tag);
    logic [3:0] elig;
    logic [3:0] exp_grant;
    int         g;
    logic       take;
    logic       give;
    #1;
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = bus.request_in[i] & bus.cmd_buffer_in[i].valid;
    g = -1;
    if (m_phase == PH_ARB && bus.enabled_in && m_credits > 0 && bus.tag_valid_in) begin
      if (elig[0]) g = 0;
      else
        foreach (m_order[j])
          if (g < 0 && elig[m_order[j]]) g = m_order[j];
    end
    exp_grant = (g >= 0) ? 4'(1 << g) : 4'd0;
    chk({tag, "_grant"}, 128'(bus.grant_out), 128'(exp_grant));
    chk({tag, "_tag_pop"}, 128'(bus.tag_pop_out), 128'(g >= 0));
    if (bus.grant_out != '0) grants_seen++;

    if (g >= 0) begin
      m_cmd                 = bus.cmd_buffer_in[g];
      m_cmd.cmd.tag         = bus.tag_in;
      m_cmd.payload.cmd.tag = bus.tag_in;
      m_cmd.valid           = 1'b1;
    end else begin
      m_cmd = '0;
    end
`ifdef CMD_ARB_ROUND_ROBIN_EN
    if (g > 0) begin
      while (m_order[0] != g) m_order.push_back(m_order.pop_front());
      m_order.push_back(m_order.pop_front());
    end
`endif
    take = (g >= 0);
    give = bus.credit_return_in;
    case (m_phase)
      PH_RESET: if (bus.enabled_in) m_phase = PH_INIT;
      PH_INIT: begin
        m_credits = int'(bus.init_credits_in);
        m_ceil    = m_credits;
        m_phase   = PH_ARB;
      end
      PH_ARB: begin
        if (take && !give) m_credits--;
        else if (give && !take) begin
          if (m_credits == m_ceil) m_err = 1'b1;
          else m_credits++;
        end
        if (!bus.enabled_in) m_phase = PH_IDLE;
      end
      default: if (bus.enabled_in) m_phase = PH_ARB;
    endcase

    @(posedge clock);
    #1;
    chk({tag, "_command"}, 128'(bus.command_out), 128'(m_cmd));
    chk({tag, "_credits"}, 128'(bus.credits_out), 128'(m_credits));
    chk({tag, "_error"}, 128'(bus.credit_error_out), 128'(m_err));
  endtask

  task automatic refill(input int n);
    bus.request_in       = '0;
    bus.credit_return_in = 1'b1;
    repeat (n) cycle("refill");
    bus.credit_return_in = 1'b0;
  endtask

  task automatic random_run(input int n);
    for (int c = 0; c < n; c++) begin
      bus.request_in = 4'($urandom);
      for (int i = 0; i < NUM_REQ; i++)
        bus.cmd_buffer_in[i] = rand_line(($urandom % 4) != 0);
      bus.tag_valid_in     = ($urandom % 4) != 0;
      bus.tag_in           = 8'($urandom);
      bus.credit_return_in = ($urandom % 3) == 0;
      bus.enabled_in       = ($urandom % 16) != 0;
      cycle("random");
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    grants_seen = 0;
    bus.enabled_in       = 1'b0;
    bus.init_credits_in  = 8'd0;
    bus.credit_return_in = 1'b0;
    bus.request_in       = '0;
    bus.tag_valid_in     = 1'b0;
    bus.tag_in           = 8'd0;
    for (int i = 0; i < NUM_REQ; i++) bus.cmd_buffer_in[i] = rand_line(1'b1);
    reset = 1'b1;
    model_reset();
    #2;
    chk_all_zero("reset");
    @(posedge clock);
    #1;
    reset = 1'b0;

    cycle("hold_disabled");
    bus.enabled_in      = 1'b1;
    bus.init_credits_in = 8'd4;
    cycle("enable");
    cycle("init");
    chk("credits_after_init", 128'(bus.credits_out), 128'(4));

    bus.request_in   = 4'b1000;
    bus.tag_valid_in = 1'b1;
    grants_seen      = 0;
    repeat (6) begin
      bus.cmd_buffer_in[3] = rand_line(1'b1);
      bus.tag_in           = 8'($urandom);
      cycle("read_burst");
    end
    chk("read_burst_count", 128'(grants_seen), 128'(4));
    chk("read_burst_credits", 128'(bus.credits_out), 128'(0));

    bus.request_in       = 4'b0100;
    bus.credit_return_in = 1'b1;
    cycle("return_at_zero");
    bus.credit_return_in = 1'b0;
    cycle("write_after_return");
    chk("write_after_return_credits", 128'(bus.credits_out), 128'(0));

    refill(4);
    bus.request_in = 4'b1011;
    repeat (2) begin
      bus.cmd_buffer_in[0] = rand_line(1'b1);
      cycle("restart_priority");
    end
    bus.request_in = 4'b1010;
    repeat (2) cycle("wed_read");

    refill(4);
    bus.request_in = 4'b1110;
    repeat (4) cycle("three_way");

    refill(4);
    bus.request_in   = 4'b1000;
    bus.tag_valid_in = 1'b0;
    cycle("no_tag");
    bus.tag_valid_in = 1'b1;
    bus.tag_in       = 8'h2A;
    cycle("tag_2a");
    chk("tag_2a_payload", 128'(bus.command_out.payload.cmd.tag), 128'(8'h2A));

    bus.credit_return_in = 1'b1;
    cycle("issue_and_return");
    chk("issue_and_return_credits", 128'(bus.credits_out), 128'(3));
    bus.request_in = '0;
    repeat (2) cycle("return_to_ceiling");
    chk("ceiling_error", 128'(bus.credit_error_out), 128'(1));
    bus.credit_return_in = 1'b0;

    bus.request_in = 4'b1000;
    bus.enabled_in = 1'b0;
    cycle("enable_fall");
    bus.enabled_in = 1'b1;
    cycle("idle_exit");
    cycle("resume");

    random_run(400);

    reset = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.enabled_in      = 1'b1;
    bus.init_credits_in = 8'($urandom_range(1, 20));
    cycle("reenable");
    cycle("reinit");
    random_run(400);

    reset = 1'b1;
    #1;
    chk_all_zero("final_reset");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/cmd_issue_arbiter.md
# cmd_issue_arbiter

Shares the single PSL command interface among the WED, restart, write and read command buffers in the AFU command path. Each cycle it grants at most one buffer and pops that buffer's head. It stamps a tag taken from the tag buffer onto the command and registers the result toward the PSL. It also tracks PSL command credits so that no command is issued without room.

## Interface
Parameters:
- `CREDIT_W`, 9, credit counter width, matching `response_credits`.
- `NUM_REQ`, 4, number of requesters. Index order: 0 restart, 1 wed, 2 write, 3 read.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `enabled_in` in 1: AFU running. When low, no grants are made.
- `init_credits_in` in 8: PSL `ha_croom` value, sampled in INIT.
- `credit_return_in` in 1: one credit returned per PSL response.
- `request_in` in `CommandBufferArbiterInterfaceIn`: per-buffer non-empty request.
- `cmd_buffer_in[NUM_REQ]` in `CommandBufferLine`: show-ahead head of each buffer.
- `tag_valid_in` in 1: tag buffer has a free tag.
- `tag_in` in 8: the free tag.
- `tag_pop_out` out 1: consume `tag_in`.
- `grant_out` out `NUM_REQ`: one-hot; pops the granted buffer.
- `command_out` out `CommandBufferLine`: registered command toward the PSL.
- `credits_out` out `CREDIT_W`: current credit count.
- `credit_error_out` out 1: sticky; set on a return that would exceed the initial credit count.

## Operation
- The state machine is RESET → INIT → ARBITRATE, with an IDLE state reachable from ARBITRATE.
  - RESET: held while `reset` is high. Exits to INIT on the first `enabled_in` high.
  - INIT: lasts one cycle. Loads the credit counter and the ceiling from `init_credits_in` (zero-extended), then goes to ARBITRATE.
  - ARBITRATE → IDLE when `enabled_in` falls. IDLE → ARBITRATE when `enabled_in` rises. Credits are held while in IDLE.
- Requester i is eligible when `request_in` bit i is set and `cmd_buffer_in[i].valid` is 1.
- A grant requires all of:
  - state is ARBITRATE,
  - credits ≥ 1,
  - `tag_valid_in` is 1,
  - at least one requester is eligible.
- Restart has strict priority. While restart is eligible, no other requester is granted.
- Among wed, write and read, selection follows the Configuration section.
- On a grant:
  - `grant_out[i]` and `tag_pop_out` are asserted in the same cycle.
  - `command_out` takes the payload of `cmd_buffer_in[i]` with `cmd.tag` and `payload.cmd.tag` replaced by `tag_in`, and `valid` set to 1.
- Credit update each cycle:
  - issue only: decrement by 1;
  - `credit_return_in` only: increment by 1;
  - both in the same cycle: unchanged.
- A return while credits equal the ceiling does not increment the counter; it sets `credit_error_out`.
- The counter never underflows, because issue is blocked at 0.

## Timing
- `grant_out` and `tag_pop_out` are combinational from the current state, inputs and counter. They are valid in the same cycle N as the conditions.
- `command_out` is registered. `command_out.valid` = 1 in cycle N+1 for exactly one cycle per grant. Throughput is one command per cycle.
- The show-ahead buffers present their next head in N+1. A requester may therefore be granted on consecutive cycles.
- Credit decrement is visible on `credits_out` in N+1.
- Reset values of every output:
  - `grant_out` = 0
  - `tag_pop_out` = 0
  - `command_out` = 0 (valid 0)
  - `credits_out` = 0
  - `credit_error_out` = 0
- Reset asserted mid-operation: all registers clear immediately and the block returns to RESET. Any command that was pending in the output register is dropped.
- `enabled_in` falling in cycle N: no grant in N if the state is still ARBITRATE only because of registered timing. The grant decision gates on `enabled_in` combinationally.

## Configuration
- Macro `CMD_ARB_ROUND_ROBIN_EN`.
- Defined: wed, write and read use round-robin. A registered pointer advances to the position just after the last granted non-restart requester. The reset value makes wed first.
- Undefined: fixed priority wed > write > read. No pointer register exists.
- Restart strict priority is the same in both builds.

## Test plan
- Reset then enable with `init_credits_in` = 4:
  - `credits_out` = 4 after INIT.
  - Continuous read requests with a tag always available → exactly 4 grants on consecutive cycles, then `grant_out` = 0 with credits = 0.
- Credits = 0 and one `credit_return_in` while a write is requesting → grant on the next cycle; `credits_out` goes 1 → 0.
- Restart, wed and read all eligible together → restart granted until its request drops, then the wed/read order per the macro.
- `CMD_ARB_ROUND_ROBIN_EN` defined, with wed, write and read held eligible → grant sequence wed, write, read, wed. Undefined → wed every cycle.
- `tag_valid_in` = 0 with credits 4 and read eligible → no grant and no `tag_pop_out`. Raise it with `tag_in` = 0x2A → `command_out.payload.cmd.tag` = 0x2A in the next cycle.
- Issue and return in the same cycle at credits 3 → credits stay 3. A return at the ceiling → credits unchanged and `credit_error_out` = 1. Assert `reset` → all outputs 0.
